// File: rtl/fetch_stage.sv
// Instruction-fetch stage with one-outstanding-request imem handshake, a one-entry
// skid buffer for responses landing during a stall, and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4_q, pc4_d;
  logic        validd_q, validd_d;
  logic        issue, captured;

  always_comb begin
    issue    = !rst && !PCSrcE && !StallF && !FlushD && !skid_valid_q &&
               (state_q == S_IDLE || (state_q == S_WAIT && imem_valid));
    captured = (state_q == S_WAIT) && imem_valid && !PCSrcE;

    state_d = state_q;
    case (state_q)
      S_IDLE: if (issue) state_d = S_WAIT;
      // A redirect with the response still in flight must swallow it in DROP.
      S_WAIT: begin
        if (PCSrcE)          state_d = imem_valid ? S_IDLE : S_DROP;
        else if (imem_valid) state_d = issue ? S_WAIT : S_IDLE;
      end
      S_DROP: if (imem_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    pcf_d    = PCSrcE ? PCTargetE : (issue ? pcf_q + 32'd4 : pcf_q);
    pc_out_d = issue ? pcf_q : pc_out_q;

    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    instr_d      = instr_q;
    pcd_d        = pcd_q;
    pc4_d        = pc4_q;
    validd_d     = validd_q;

    if (FlushD) begin
      instr_d = NOP_INSTR; pcd_d = '0; pc4_d = '0; validd_d = 1'b0;
    end else if (StallF) begin
      // hold
    end else if (skid_valid_q) begin
      instr_d = skid_instr_q; pcd_d = skid_pc_q; pc4_d = skid_pc_q + 32'd4;
      validd_d = 1'b1; skid_valid_d = 1'b0;
    end else if (captured) begin
      instr_d = imem_rdata; pcd_d = pc_out_q; pc4_d = pc_out_q + 32'd4;
      validd_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR; pcd_d = '0; pc4_d = '0; validd_d = 1'b0;
    end

    // Issue is blocked while the skid is full, so a second fill cannot happen.
    if (captured && (StallF || FlushD || skid_valid_q)) begin
      skid_valid_d = 1'b1;
      skid_instr_d = imem_rdata;
      skid_pc_d    = pc_out_q;
    end
    if (PCSrcE) skid_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pcf_q        <= RESET_PC;
      pc_out_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      instr_q      <= NOP_INSTR;
      pcd_q        <= '0;
      pc4_q        <= '0;
      validd_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pcf_q        <= pcf_d;
      pc_out_q     <= pc_out_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      instr_q      <= instr_d;
      pcd_q        <= pcd_d;
      pc4_q        <= pc4_d;
      validd_q     <= validd_d;
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pcf_q;
  assign InstrD    = instr_q;
  assign PCD       = pcd_q;
  assign PCPlus4D  = pc4_q;
  assign ValidD    = validd_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable imem model plus a queue of
// expected IF/ID deliveries checked whenever decode receives a new valid word.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, StallF, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // imem model: one outstanding request, response lat cycles after the request
  int          lat = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .StallF(StallF), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  assign imem_valid = mem_busy && (mem_cnt == 1);
  assign imem_rdata = mem_addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (rst) mem_busy <= 1'b0;
    else begin
      if (mem_busy && mem_cnt == 1) mem_busy <= 1'b0;
      else if (mem_busy)            mem_cnt  <= mem_cnt - 1;
      if (imem_req) begin
        mem_busy <= 1'b1;
        mem_cnt  <= lat;
        mem_addr <= imem_addr;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; a valid IF/ID word not held by a stall is a new delivery.
  task automatic step();
    logic hold;
    logic [31:0] e;
    hold = StallF && !FlushD && !rst;
    @(posedge clk);
    #1;
    if (ValidD === 1'b1 && !hold) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++;
        $error("FAIL unexpected_delivery: got PCD %h expected no delivery", PCD);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("deliv_pcd", PCD, e);
        chk("deliv_instr", InstrD, e ^ 32'hA5A5_0000);
        chk("deliv_pc4", PCPlus4D, e + 32'd4);
      end
    end
  endtask

  initial begin
    rst = 1'b1; StallF = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    step(); step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ValidD}, 32'd0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pc4", PCPlus4D, 32'd0);

    // streaming, L=1
    rst = 1'b0; #1;
    chk("a0_req", {31'd0, imem_req}, 32'd1);
    chk("a0_addr", imem_addr, 32'h0);
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    step();
    chk("a1_addr", imem_addr, 32'h4);
    step();
    chk("a2_addr", imem_addr, 32'h8);

    // stall while the 0x8 response lands -> skid
    step();
    StallF = 1'b1; #1;
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    step(); step();
    chk("stall_hold_pcd", PCD, 32'h4);
    chk("stall_hold_valid", {31'd0, ValidD}, 32'd1);
    chk("stall_req2", {31'd0, imem_req}, 32'd0);
    step();
    StallF = 1'b0; #1;
    chk("drain_req", {31'd0, imem_req}, 32'd0);
    exp_q.push_back(32'hC);
    step();
    chk("after_drain_req", {31'd0, imem_req}, 32'd1);
    chk("after_drain_addr", imem_addr, 32'hC);

    // L=3 redirect while 0x10 outstanding
    step();
    lat = 3;
    chk("req_10", imem_addr, 32'h10);
    step();
    PCSrcE = 1'b1; PCTargetE = 32'h100; #1;
    chk("redir_req", {31'd0, imem_req}, 32'd0);
    step();
    PCSrcE = 1'b0; #1;
    chk("drop_req", {31'd0, imem_req}, 32'd0);
    chk("drop_valid", {31'd0, ValidD}, 32'd0);
    step();
    chk("drop_resp_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("tgt_req", {31'd0, imem_req}, 32'd1);
    chk("tgt_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    step(); step(); step();
    chk("req_104", imem_addr, 32'h104);
    chk("req_104_v", {31'd0, imem_req}, 32'd1);

    // flush+stall with full skid
    step();
    lat = 1;
    step();
    step();
    StallF = 1'b1; #1;
    chk("skid_fill_req", {31'd0, imem_req}, 32'd0);
    step();
    FlushD = 1'b1; #1;
    chk("fs_req", {31'd0, imem_req}, 32'd0);
    step();
    StallF = 1'b0; FlushD = 1'b0; #1;
    chk("fs_valid", {31'd0, ValidD}, 32'd0);
    chk("fs_instr", InstrD, NOP);
    chk("fs_pcd", PCD, 32'd0);
    chk("fs_drain_req", {31'd0, imem_req}, 32'd0);
    exp_q.push_back(32'h104);
    step();
    chk("req_108", imem_addr, 32'h108);
    chk("req_108_v", {31'd0, imem_req}, 32'd1);

    // reset during WAIT
    step();
    rst = 1'b1; #1;
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    step();
    rst = 1'b0; #1;
    chk("post_rst_valid", {31'd0, ValidD}, 32'd0);
    chk("post_rst_instr", InstrD, NOP);
    chk("post_rst_pcd", PCD, 32'd0);
    chk("post_rst_pc4", PCPlus4D, 32'd0);
    chk("post_rst_req", {31'd0, imem_req}, 32'd1);
    chk("post_rst_addr", imem_addr, 32'h0);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(4 * k));
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("stream_addr", imem_addr, 32'(4 * i));
    end

    // redirect+flush coincident with 0x20 response
    step();
    PCSrcE = 1'b1; FlushD = 1'b1; PCTargetE = 32'h100; #1;
    chk("rf_req", {31'd0, imem_req}, 32'd0);
    step();
    PCSrcE = 1'b0; FlushD = 1'b0; #1;
    chk("rf_valid", {31'd0, ValidD}, 32'd0);
    chk("rf_instr", InstrD, NOP);
    chk("rf_req2", {31'd0, imem_req}, 32'd1);
    chk("rf_addr", imem_addr, 32'h100);
    exp_q.push_back(32'h100);
    step(); step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. It sits directly upstream of the decode stage. It owns the fetch PC, issues one request at a time on a handshaked instruction-memory port, and absorbs responses that arrive while decode is stalled using a one-entry skid buffer. It delivers InstrD/PCD/PCPlus4D/ValidD to decode, and honours execute-stage redirects and hazard-unit stall/flush.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- NOP_INSTR, 32'h0000_0013: bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- StallF  in  1  hazard unit: hold the IF/ID register and block new requests.
- FlushD  in  1  hazard unit: load a bubble into IF/ID. Has priority over StallF.
- PCSrcE  in  1  execute redirect (taken branch or jump).
- PCTargetE  in  32  redirect target.
- imem_req  out  1  request strobe; one cycle per request.
- imem_addr  out  32  request address; equals internal PCF.
- imem_rdata  in  32  instruction; valid only when imem_valid=1.
- imem_valid  in  1  response strobe; exactly one per request, at least 1 cycle after the request.
- InstrD  out  32  IF/ID instruction to decode.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  1 when InstrD is a real fetched instruction, 0 for a bubble.

## Operation
- State: PCF (next address), pc_out (address of the outstanding request), FSM {IDLE, WAIT, DROP}, skid {skid_valid, skid_instr, skid_pc}, IF/ID {InstrD, PCD, PCPlus4D, ValidD}.
- Reset values: PCF=RESET_PC, FSM=IDLE, skid_valid=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0. imem_req=0 while rst=1.
- Issue: imem_req = !PCSrcE && !StallF && !FlushD && !skid_valid && (FSM==IDLE || (FSM==WAIT && imem_valid)). On issue: pc_out<=PCF, PCF<=PCF+4 (mod 2^32), FSM<=WAIT.
- Capture: captured = FSM==WAIT && imem_valid && !PCSrcE.
- FSM transitions:
  - IDLE: issue→WAIT, else stay. imem_valid in IDLE is ignored.
  - WAIT:
    - PCSrcE && !imem_valid → DROP.
    - PCSrcE && imem_valid → IDLE, response discarded.
    - imem_valid && issue → WAIT.
    - imem_valid && !issue → IDLE.
    - otherwise stay.
  - DROP: imem_valid → IDLE, response discarded. PCSrcE in DROP updates PCF only.
- Redirect: PCSrcE → PCF<=PCTargetE, skid_valid<=0, no issue that cycle. IF/ID is bubbled only via FlushD, which the hazard unit asserts alongside PCSrcE.
- IF/ID update, highest priority first:
  1. FlushD → {NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0}.
  2. StallF → hold.
  3. skid_valid → load the skid entry (PCPlus4D=skid_pc+4, ValidD=1), clear skid.
  4. captured → load {imem_rdata, pc_out, pc_out+4, 1}.
  5. Otherwise → bubble.
- Skid fill: captured while (StallF || FlushD || skid_valid) → skid<={imem_rdata, pc_out}. By construction no issue occurs while the skid is full, so a second fill is impossible. The skid is never overwritten.
- An instruction is never lost or duplicated: each fetched word reaches IF/ID with ValidD=1 exactly once, unless a redirect discards it.

## Timing
- Memory latency L≥1: a request issued in cycle t delivers its response in cycle t+L, and it is visible in IF/ID after the edge ending t+L.
- L=1, no stalls: one request per cycle, ValidD=1 every cycle from the third cycle after reset release.
- Reset release: first imem_req in the first cycle with rst=0 (FSM IDLE).
- Redirect latency: the target request issues in the cycle after PCSrcE (IDLE), or in the cycle after the outstanding response drains (DROP).
- Skid drain: after StallF falls, the skid moves to IF/ID at the next edge. The next request issues the cycle after that (one bubble cost, accepted).
- rst mid-operation: all state returns to reset values at the edge. The memory is reset by the same rst, so no stale response follows.

## Test plan
- Reset, then L=1 memory returning rdata=addr^32'hA5A5_0000 → requests to 0x0, 0x4, 0x8, … on consecutive cycles; IF/ID shows PCD 0x0, 0x4, 0x8 back-to-back with ValidD=1 and PCPlus4D=PCD+4.
- L=1, StallF=1 for 3 cycles while the response for 0x8 arrives → IF/ID holds PCD=0x4, skid holds 0x8, imem_req=0; after release PCD=0x8, then the request for 0xC issues; 0x8 appears exactly once.
- L=3, PCSrcE=1 with PCTargetE=0x100 one cycle after the request for 0x10 → FSM=DROP, the 0x10 response is discarded, the next imem_addr is 0x100, and no ValidD=1 with PCD=0x10 ever occurs.
- PCSrcE+FlushD in the same cycle as a response for 0x20 → response dropped, IF/ID={NOP, ValidD=0}, request 0x100 issues the next cycle.
- FlushD=1 and StallF=1 together with a full skid → IF/ID becomes a NOP bubble and the skid entry is not consumed; it loads once both signals fall.
- rst=1 for one cycle during WAIT → next cycle all outputs are at reset values; the first request after release is RESET_PC.
